// File: rtl/jk_bank_arbiter.sv
// Bank of N JK flip-flop bits with round-robin, lockable write access for NREQ requesters.
// One command is applied per cycle; q and the update/err pulses appear one edge after acceptance.
module jk_bank_arbiter #(
  parameter int N    = 8,
  parameter int AW   = 3,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*2-1:0] req_op,
  input  logic [NREQ-1:0]   req_lock,
  output logic [NREQ-1:0]   req_ready,
  output logic [N-1:0]      q,
  output logic              upd_valid,
  output logic [2:0]        upd_id,
  output logic              err,
  output logic              dbg_locked,
  output logic [2:0]        dbg_owner
);

  // Handshake: requester i's command is accepted on a rising edge where req_valid[i] and
  // req_ready[i] are both 1; ready is combinational and at most one-hot, valid must be held
  // (with stable addr/op/lock) until accepted, and ready never waits on anything but valid.

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [2:0]      rr_ptr, rr_next;
  logic [2:0]      owner, owner_next;
  logic [3:0]      idx;
  logic            win_any;
  logic [2:0]      win_id;
  logic [AW-1:0]   win_addr;
  logic [1:0]      win_op;
  logic            win_lock;
  logic            win_in_range;
  logic [N-1:0]    q_next;

  // Winner selection: owner only while locked, otherwise first valid at or after rr_ptr.
  always_comb begin
    win_any = 1'b0;
    win_id  = 3'd0;
    idx     = 4'd0;
    if (state == LOCKED) begin
      win_id = owner;
      for (int j = 0; j < NREQ; j++) begin
        if (3'(j) == owner) win_any = req_valid[j];
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        idx = {1'b0, rr_ptr} + 4'(k);
        if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
        for (int j = 0; j < NREQ; j++) begin
          if (!win_any && (idx == 4'(j)) && req_valid[j]) begin
            win_any = 1'b1;
            win_id  = 3'(j);
          end
        end
      end
    end
    if (rst) win_any = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    for (int j = 0; j < NREQ; j++) begin
      req_ready[j] = win_any && (win_id == 3'(j));
    end
  end

  always_comb begin
    win_addr = '0;
    win_op   = 2'b00;
    win_lock = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (win_id == 3'(j)) begin
        win_addr = req_addr[j*AW +: AW];
        win_op   = req_op[j*2 +: 2];
        win_lock = req_lock[j];
      end
    end
  end

  assign win_in_range = ({{(32-AW){1'b0}}, win_addr} < 32'(N));

  always_comb begin
    q_next = q;
    if (win_any && win_in_range) begin
      for (int j = 0; j < N; j++) begin
        if ({{(32-AW){1'b0}}, win_addr} == 32'(j)) begin
          case (win_op)
            2'b01:   q_next[j] = 1'b0;
            2'b10:   q_next[j] = 1'b1;
            2'b11:   q_next[j] = ~q[j];
            default: q_next[j] = q[j];
          endcase
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
    rr_next    = rr_ptr;
    if (win_any) begin
      rr_next = (win_id == 3'(NREQ-1)) ? 3'd0 : win_id + 3'd1;
      if (win_lock) begin
        state_next = LOCKED;
        owner_next = win_id;
      end else begin
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= 3'd0;
      rr_ptr <= 3'd0;
    end else begin
      state  <= state_next;
      owner  <= owner_next;
      rr_ptr <= rr_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q         <= '0;
      upd_valid <= 1'b0;
      upd_id    <= 3'd0;
      err       <= 1'b0;
    end else begin
      q         <= q_next;
      upd_valid <= win_any;
      err       <= win_any && !win_in_range;
      if (win_any) upd_id <= win_id;
    end
  end

  assign dbg_locked = (state == LOCKED);
  assign dbg_owner  = owner;

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Owns a bank of N JK flip-flop bits and shares write access to it among NREQ requesters.
- Each requester issues JK commands (hold, clear, set, toggle) to one bit address through a valid/ready handshake.
- Arbitration is round-robin, and a requester can lock the bank for back-to-back commands.
- Sits between control-side command sources and any logic consuming the bank output q.

Parameters:
- N, 8, number of JK bits in the bank.
- AW, 3, address width of each requester's addr field.
- NREQ, 4, number of requesters (2..8).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester command valid.
- req_addr  input  NREQ*AW  per-requester bit address; requester i occupies slice [i*AW +: AW].
- req_op  input  NREQ*2  per-requester command {J,K}, slice [i*2 +: 2]: 00 hold, 01 clear, 10 set, 11 toggle.
- req_lock  input  NREQ  requester keeps ownership after the current command.
- req_ready  output  NREQ  one-hot or zero grant; the command is accepted on a cycle where valid and ready are both 1.
- q  output  N  bank state.
- upd_valid  output  1  registered pulse: one command was accepted in the previous cycle.
- upd_id  output  3  registered index of the accepted requester.
- err  output  1  registered pulse: the accepted command had addr >= N, so no bit changed.

Behaviour:
- Reset (asynchronous, active-high): q=0, upd_valid=0, upd_id=0, err=0, rr_ptr=0, state=IDLE, owner=0. req_ready is combinational and is 0 while rst=1.
- req_ready is combinational from req_valid, state, owner and rr_ptr. At most one bit is set.
- IDLE arbitration:
  - Scan requesters starting at rr_ptr, wrapping modulo NREQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1.
  - No valid requests: req_ready=0.
- LOCKED arbitration:
  - req_ready[owner]=req_valid[owner]; all other ready bits are 0.
  - Owner valid low: no grant, state stays LOCKED. A locked owner stalls everyone else indefinitely; this is intended.
- Acceptance at a clock edge, winner w:
  - addr < N: q[addr] updates per op. Hold leaves it unchanged, clear sets 0, set sets 1, toggle inverts. All other q bits are unchanged.
  - addr >= N: q is unchanged and err is 1 next cycle.
  - upd_valid=1 and upd_id=w next cycle. Latency from acceptance edge to visible q/upd is one edge.
  - rr_ptr <= (w+1) mod NREQ, updated in both IDLE and LOCKED.
  - req_lock[w]=1: state <= LOCKED, owner <= w.
  - req_lock[w]=0: state <= IDLE.
- No acceptance in a cycle: upd_valid=0 and err=0 next cycle. upd_id, rr_ptr, state, owner and q hold.
- Exactly one command is applied per cycle; simultaneous requests never merge.
- Inputs of non-granted requesters are ignored. They must hold valid until they are granted; the block does not check this.
- Reset asserted mid-operation or while LOCKED clears immediately to the reset state. Any command on that edge is discarded.
- Fairness: with all NREQ valid and unlocked, grants go 0,1,2,...,NREQ-1,0,... from reset.

Test Plan:
- Reset then single command: after reset, req0 valid, addr=3, op=10 (set) → req_ready=0001 in the same cycle; next cycle q=0x08, upd_valid=1, upd_id=0, err=0.
- Op coverage on bit 5: set, toggle, toggle, clear, hold → q[5] after each edge is 1,0,1,0,0; other bits remain 0.
- Round-robin: all four requesters valid and unlocked for 8 cycles, each setting its own bit → upd_id sequence 0,1,2,3,0,1,2,3; q=0x0F after 4 grants.
- Lock: req2 accepted with lock=1 while req0/1/3 valid → only req2 granted for 3 commands. Req2 then issues a command with lock=0 → the next grant goes to req3 (rr_ptr=3).
- Out-of-range with N=6, AW=3: addr=7, op=10 → q unchanged, err=1 and upd_valid=1 for one cycle. A following valid addr=5 set → q=0x20, err=0.
- Async reset mid-lock: rst pulsed between clock edges while state=LOCKED with q=0x3C → q=0, req_ready=0 during reset. After release, req0 is granted first (rr_ptr=0).
